// File: rtl/dmem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_pkg
// Shared definitions for the MEM-stage data-memory access sequencer:
//   - load / store type encodings as delivered by the decode control path
//   - fault_cause codes reported alongside done
//   - sequencer FSM state encoding
//   - internal access-size classification
//   - default timeout depth and timeout counter width
// -----------------------------------------------------------------------------
package dmem_access_ctrl_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYC = 255;
  localparam int unsigned DEFAULT_TO_W        = 16;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    ST_B = 2'b00,
    ST_H = 2'b01,
    ST_W = 2'b10
  } store_type_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_BUS_ERR  = 2'b10,
    FC_TIMEOUT  = 2'b11
  } fault_cause_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUS  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // SZ_BAD marks an undefined type encoding or a read+write conflict.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Single-outstanding req/ack data bus between the access sequencer (master)
// and the data memory / interconnect (slave).
//   bus_req   : access request, held until bus_ack or timeout
//   bus_we    : 1 = write
//   bus_addr  : word-aligned byte address
//   bus_be    : byte enables
//   bus_wdata : lane-replicated store data
//   bus_ack   : access complete
//   bus_rdata : read word, valid with bus_ack
//   bus_err   : qualifies bus_ack as an error response
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/dmem_access_ctrl_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load-data alignment and extension.
//   word      : 32-bit word returned by the bus
//   offset    : byte offset of the access within the word
//   load_type : LB/LH/LW/LBU/LHU
//   ext       : right-aligned, sign- or zero-extended load value
// -----------------------------------------------------------------------------
module load_extend
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  load_type_e  load_type,
  output logic [31:0] ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // NOTE: every output of a combinational block gets a default before any
  // branch so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    sel_byte = word[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? word[31:16] : word[15:0];
    ext      = word;
    case (load_type)
      LD_B:    ext = {{24{sel_byte[7]}}, sel_byte};
      LD_BU:   ext = {24'b0, sel_byte};
      LD_H:    ext = {{16{sel_half[15]}}, sel_half};
      LD_HU:   ext = {16'b0, sel_half};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage data-memory access sequencer. Turns a load/store request into one
// bus transaction, stalls the pipeline until it completes, and returns
// extended load data or a fault.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid       : MEM stage holds a valid memory instruction
//   mem_read/write  : load / store
//   mem_load_type   : LB/LH/LW/LBU/LHU
//   mem_store_type  : SB/SH/SW
//   addr, wdata     : effective byte address, store data
//   stall           : combinational pipeline freeze
//   done            : one-cycle completion pulse
//   rdata           : extended load data (0 for stores), valid with done
//   fault, fault_cause : fault flag and cause, valid with done
//   bus             : req/ack data bus (master side)
// -----------------------------------------------------------------------------
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int unsigned TO_W        = DEFAULT_TO_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          mem_load_type,
  input  logic [1:0]          mem_store_type,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                stall,
  output logic                done,
  output logic [31:0]         rdata,
  output logic                fault,
  output logic [1:0]          fault_cause,
  dmem_access_ctrl_if.master  bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_e       state_q, state_d;
  logic         req_q, req_d;
  logic         we_q, we_d;
  logic [31:0]  baddr_q, baddr_d;
  logic [3:0]   be_q, be_d;
  logic [31:0]  bwdata_q, bwdata_d;
  logic [1:0]   off_q, off_d;
  load_type_e   ltype_q, ltype_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         fault_q, fault_d;
  fault_cause_e cause_q, cause_d;
  logic [31:0]  rdata_q, rdata_d;

  logic         acc;
  size_e        size;
  logic         reject;
  logic [3:0]   lane_be;
  logic [31:0]  lane_wdata;
  logic [31:0]  ld_ext;

  // Request decode: access size, legality and lane placement.
  always_comb begin
    acc  = req_valid & (mem_read | mem_write);
    size = SZ_BAD;
    if (mem_read && !mem_write) begin
      case (mem_load_type)
        LD_B, LD_BU: size = SZ_BYTE;
        LD_H, LD_HU: size = SZ_HALF;
        LD_W:        size = SZ_WORD;
        default:     size = SZ_BAD;
      endcase
    end else if (mem_write && !mem_read) begin
      case (mem_store_type)
        ST_B:    size = SZ_BYTE;
        ST_H:    size = SZ_HALF;
        ST_W:    size = SZ_WORD;
        default: size = SZ_BAD;
      endcase
    end

    reject = (size == SZ_BAD)
           | ((size == SZ_HALF) & addr[0])
           | ((size == SZ_WORD) & (addr[1:0] != 2'b00));

    case (size)
      SZ_BYTE: begin
        lane_be    = 4'b0001 << addr[1:0];
        lane_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_be    = 4'b0011 << {addr[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata;
      end
    endcase
  end

  // Extraction uses the registered offset/type, so requester inputs may
  // change during BUS without affecting the result.
  load_extend u_load_extend (
    .word      (bus.bus_rdata),
    .offset    (off_q),
    .load_type (ltype_q),
    .ext       (ld_ext)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    baddr_d  = baddr_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    off_d    = off_q;
    ltype_d  = ltype_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    cause_d  = FC_NONE;

    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (reject) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
            cause_d = FC_MISALIGN;
            rdata_d = '0;
          end else begin
            state_d  = S_BUS;
            req_d    = 1'b1;
            we_d     = mem_write;
            baddr_d  = {addr[31:2], 2'b00};
            be_d     = lane_be;
            bwdata_d = lane_wdata;
            off_d    = addr[1:0];
            ltype_d  = load_type_e'(mem_load_type);
            cnt_d    = '0;
          end
        end
      end

      S_BUS: begin
        // bus_ack is tested first so an ack on the timeout cycle wins.
        if (bus.bus_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          if (bus.bus_err) begin
            fault_d = 1'b1;
            cause_d = FC_BUS_ERR;
            rdata_d = '0;
          end else begin
            rdata_d = we_q ? 32'b0 : ld_ext;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          fault_d = 1'b1;
          cause_d = FC_TIMEOUT;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset as well, because their
    // post-reset value is visible on the bus and result ports.
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      be_q     <= '0;
      bwdata_q <= '0;
      off_q    <= '0;
      ltype_q  <= LD_B;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      cause_q  <= FC_NONE;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
      off_q    <= off_d;
      ltype_q  <= ltype_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      cause_q  <= cause_d;
      rdata_q  <= rdata_d;
    end
  end

  assign stall         = ((state_q == S_IDLE) & acc) | (state_q == S_BUS);
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = baddr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = bwdata_q;

endmodule
